// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Two-requester round-robin arbiter for the kianv native
//                memory bus (valid/ready, 32-bit addr/data, 4-bit wmask).
//                A grant is held for exactly one transaction; an optional
//                watchdog aborts a hung transaction with an error pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
   parameter int TIMEOUT = 0,   // 0 disables the watchdog
   parameter int CNT_W   = 16   // must satisfy TIMEOUT < 2**CNT_W
) (
   input  logic        clk,
   input  logic        resetn,

   input  logic        req0_valid,
   input  logic [31:0] req0_addr,
   input  logic [31:0] req0_wdata,
   input  logic [3:0]  req0_wmask,
   output logic        req0_ready,
   output logic [31:0] req0_rdata,

   input  logic        req1_valid,
   input  logic [31:0] req1_addr,
   input  logic [31:0] req1_wdata,
   input  logic [3:0]  req1_wmask,
   output logic        req1_ready,
   output logic [31:0] req1_rdata,

   output logic        mem_valid,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wmask,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,

   output logic        timeout_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } state_t;

   // Counter value reached in the TIMEOUT-th granted cycle (first cycle = 0)
   localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic             c_WD_EN    = (TIMEOUT != 0);

   state_t           r_state;
   logic             r_last;    // last requester served; 1 so requester 0 wins the first tie
   logic [CNT_W-1:0] r_cnt;

   logic             w_granted;
   logic             w_abort;
   logic             w_done;
   logic [31:0]      w_rdata;

   assign w_granted = (r_state != IDLE);
   // A real mem_ready in the last allowed cycle takes priority over the abort
   assign w_abort   = c_WD_EN & w_granted & ~mem_ready & (r_cnt == c_CNT_LAST);
   assign w_done    = w_granted & (mem_ready | w_abort);
   assign w_rdata   = w_abort ? 32'hFFFF_FFFF : mem_rdata;

   // Grant FSM with round-robin tie break and saturating watchdog counter
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= IDLE;
         r_last  <= 1'b1;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               r_cnt <= '0;
               if (req0_valid && req1_valid)
                  r_state <= r_last ? GNT0 : GNT1;
               else if (req0_valid)
                  r_state <= GNT0;
               else if (req1_valid)
                  r_state <= GNT1;
            end
            GNT0, GNT1: begin
               if (w_done) begin
                  r_state <= IDLE;
                  r_last  <= (r_state == GNT1);
               end else if (r_cnt != {CNT_W{1'b1}}) begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Route the grantee's fields to memory and the completion back to it
   always_comb begin
      mem_valid  = 1'b0;
      mem_addr   = 32'h0;
      mem_wdata  = 32'h0;
      mem_wmask  = 4'h0;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      case (r_state)
         GNT0: begin
            mem_valid  = req0_valid & ~w_abort;
            mem_addr   = req0_addr;
            mem_wdata  = req0_wdata;
            mem_wmask  = req0_wmask;
            req0_ready = mem_ready | w_abort;
         end
         GNT1: begin
            mem_valid  = req1_valid & ~w_abort;
            mem_addr   = req1_addr;
            mem_wdata  = req1_wdata;
            mem_wmask  = req1_wmask;
            req1_ready = mem_ready | w_abort;
         end
         default: ;
      endcase
   end

   assign req0_rdata  = w_rdata;
   assign req1_rdata  = w_rdata;
   assign timeout_err = w_abort;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Scoreboard bench for mem_arbiter. Requester drivers and a
//                memory responder run independently; expected completions
//                are queued at stimulus time and checked by a monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

   localparam int          TIMEOUT = 5;
   localparam int          CNT_W   = 16;
   localparam logic [31:0] c_XOR   = 32'h5A5A_5A5A;   // memory returns addr ^ c_XOR

   logic        clk;
   logic        resetn;
   logic        req0_valid, req1_valid;
   logic [31:0] req0_addr, req1_addr, req0_wdata, req1_wdata;
   logic [3:0]  req0_wmask, req1_wmask;
   logic        req0_ready, req1_ready;
   logic [31:0] req0_rdata, req1_rdata;
   logic        mem_valid;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wmask;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        timeout_err;

   mem_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk(clk), .resetn(resetn),
      .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
      .req0_wmask(req0_wmask), .req0_ready(req0_ready), .req0_rdata(req0_rdata),
      .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
      .req1_wmask(req1_wmask), .req1_ready(req1_ready), .req1_rdata(req1_rdata),
      .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wmask(mem_wmask), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .timeout_err(timeout_err)
   );

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wmask;
   } req_t;

   typedef struct {
      int          id;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wmask;
      logic [31:0] rdata;
      logic        err;
      int          lat;   // granted cycle in which completion occurs
      int          gap;   // cycles since previous completion, 0 = unchecked
   } exp_t;

   req_t rq0[$];
   req_t rq1[$];
   exp_t exp_q[$];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int ws       = 0;   // memory wait states
   bit never    = 0;   // memory never answers

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("FAIL global time limit reached");
      $fatal(1, "time limit");
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic push_req(input int id, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] wm);
      req_t t;
      t.addr = a; t.wdata = wd; t.wmask = wm;
      if (id == 0) rq0.push_back(t);
      else         rq1.push_back(t);
   endtask

   function automatic exp_t mk_exp(input int id, input logic [31:0] a, input logic [31:0] wd,
                                   input logic [3:0] wm, input logic [31:0] rd,
                                   input logic err, input int lat, input int gap);
      exp_t e;
      e.id = id; e.addr = a; e.wdata = wd; e.wmask = wm;
      e.rdata = rd; e.err = err; e.lat = lat; e.gap = gap;
      return e;
   endfunction

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || rq0.size() != 0 || rq1.size() != 0 ||
              req0_valid || req1_valid) && n < 300) begin
         @(negedge clk);
         n++;
      end
      n_checks++;
      if (n >= 300) begin
         n_fail++;
         $display("FAIL %s drain: %0d completions still pending after %0d cycles", name,
                  exp_q.size(), n);
      end
      repeat (2) @(negedge clk);
   endtask

   // Requester 0 driver: holds valid until its ready, then takes the next entry
   initial begin : drv0
      req_t t;
      int   n;
      req0_valid = 1'b0; req0_addr = '0; req0_wdata = '0; req0_wmask = '0;
      forever begin
         @(posedge clk); #1;
         if (rq0.size() == 0) begin
            req0_valid = 1'b0;
         end else begin
            t = rq0.pop_front();
            req0_valid = 1'b1; req0_addr = t.addr; req0_wdata = t.wdata; req0_wmask = t.wmask;
            n = 0;
            do begin @(negedge clk); n++; end while (!req0_ready && n < 300);
            if (!req0_ready) begin
               n_checks++; n_fail++;
               $display("FAIL req0 ready wait: none after %0d cycles", n);
            end
         end
      end
   end

   // Requester 1 driver
   initial begin : drv1
      req_t t;
      int   n;
      req1_valid = 1'b0; req1_addr = '0; req1_wdata = '0; req1_wmask = '0;
      forever begin
         @(posedge clk); #1;
         if (rq1.size() == 0) begin
            req1_valid = 1'b0;
         end else begin
            t = rq1.pop_front();
            req1_valid = 1'b1; req1_addr = t.addr; req1_wdata = t.wdata; req1_wmask = t.wmask;
            n = 0;
            do begin @(negedge clk); n++; end while (!req1_ready && n < 300);
            if (!req1_ready) begin
               n_checks++; n_fail++;
               $display("FAIL req1 ready wait: none after %0d cycles", n);
            end
         end
      end
   end

   // Memory responder: answers after ws wait states unless 'never' is set
   initial begin : mem_model
      bit busy;
      int wc;
      busy = 0; wc = 0;
      mem_ready = 1'b0; mem_rdata = '0;
      forever begin
         @(posedge clk); #1;
         mem_ready = 1'b0; mem_rdata = '0;
         if (!resetn) begin
            busy = 0;
         end else begin
            if (!busy && mem_valid) begin busy = 1; wc = 0; end
            if (busy) begin
               wc++;
               if (!never && wc == ws + 1) begin
                  mem_ready = 1'b1;
                  mem_rdata = mem_addr ^ c_XOR;
               end
            end
         end
         @(negedge clk);
         if (req0_ready || req1_ready || !resetn) busy = 0;
      end
   end

   // Monitor: checks memory-side fields each granted cycle and each completion
   initial begin : mon
      exp_t        e;
      bit          inflight;
      int          gc, prev_done, got_id;
      logic [31:0] got_rd;
      inflight = 0; gc = 0; prev_done = 0;
      forever begin
         @(negedge clk);
         if (!resetn) begin
            inflight = 0;
            continue;
         end
         if (!inflight && mem_valid) begin inflight = 1; gc = 0; end
         if (inflight) gc++;
         if (mem_valid) begin
            if (exp_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL unexpected mem_valid: addr %h with nothing expected", mem_addr);
            end else begin
               e = exp_q[0];
               chk("mem_addr", mem_addr, e.addr);
               chk("mem_wdata", mem_wdata, e.wdata);
               chk("mem_wmask", 32'(mem_wmask), 32'(e.wmask));
               chk("non-grantee ready", 32'(e.id == 0 ? req1_ready : req0_ready), 32'h0);
            end
         end
         if (req0_ready || req1_ready || timeout_err) begin
            if (exp_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL unexpected completion: req0_ready %b req1_ready %b err %b",
                        req0_ready, req1_ready, timeout_err);
            end else begin
               e = exp_q.pop_front();
               got_id = (req0_ready && req1_ready) ? 2 : (req1_ready ? 1 : (req0_ready ? 0 : -1));
               got_rd = (e.id == 1) ? req1_rdata : req0_rdata;
               chk("grantee id", 32'(got_id), 32'(e.id));
               chk("rdata", got_rd, e.rdata);
               chk("timeout_err", 32'(timeout_err), 32'(e.err));
               chk("completion latency", 32'(gc), 32'(e.lat));
               chk("mem_valid at completion", 32'(mem_valid), 32'(!e.err));
               if (e.gap != 0) chk("completion spacing", 32'(cyc - prev_done), 32'(e.gap));
            end
            prev_done = cyc;
            inflight  = 0;
         end
      end
   end

   // Directed stimulus
   initial begin : stim
      int n;
      resetn = 1'b0;

      // Reset with both requesters valid; requester 0 must win the first tie
      push_req(0, 32'h0000_0100, 32'h1111_1111, 4'hF);
      push_req(1, 32'h0000_0200, 32'h2222_2222, 4'h0);
      exp_q.push_back(mk_exp(0, 32'h0000_0100, 32'h1111_1111, 4'hF, 32'h5A5A_5B5A, 1'b0, 1, 0));
      exp_q.push_back(mk_exp(1, 32'h0000_0200, 32'h2222_2222, 4'h0, 32'h5A5A_585A, 1'b0, 1, 2));
      repeat (3) @(negedge clk);
      chk("reset mem_valid", 32'(mem_valid), 32'h0);
      chk("reset mem_addr", mem_addr, 32'h0);
      chk("reset mem_wdata", mem_wdata, 32'h0);
      chk("reset mem_wmask", 32'(mem_wmask), 32'h0);
      chk("reset req0_ready", 32'(req0_ready), 32'h0);
      chk("reset req1_ready", 32'(req1_ready), 32'h0);
      chk("reset timeout_err", 32'(timeout_err), 32'h0);
      chk("reset req0_rdata", req0_rdata, 32'h0);
      @(posedge clk); #1 resetn = 1'b1;
      @(negedge clk);
      chk("mem_valid before first grant", 32'(mem_valid), 32'h0);
      @(negedge clk);
      chk("mem_valid one cycle after release", 32'(mem_valid), 32'h1);
      chk("first grant addr", mem_addr, 32'h0000_0100);
      wait_drain("reset");

      // Contention: both continuously valid, zero-wait memory, strict alternation
      for (int i = 0; i < 4; i++) begin
         push_req(0, 32'h0000_2000 + 32'(8 * i), 32'h0000_00A0 + 32'(i), 4'hF);
         push_req(1, 32'h0000_3000 + 32'(8 * i), 32'h0000_00B0 + 32'(i), 4'h0);
         exp_q.push_back(mk_exp(0, 32'h0000_2000 + 32'(8 * i), 32'h0000_00A0 + 32'(i), 4'hF,
                                (32'h0000_2000 + 32'(8 * i)) ^ c_XOR, 1'b0, 1, (i == 0) ? 0 : 2));
         exp_q.push_back(mk_exp(1, 32'h0000_3000 + 32'(8 * i), 32'h0000_00B0 + 32'(i), 4'h0,
                                (32'h0000_3000 + 32'(8 * i)) ^ c_XOR, 1'b0, 1, 2));
      end
      wait_drain("contention");

      // Field routing: requester 1 write with 3 wait states
      ws = 3;
      push_req(1, 32'h0000_1004, 32'hDEAD_BEEF, 4'b0011);
      exp_q.push_back(mk_exp(1, 32'h0000_1004, 32'hDEAD_BEEF, 4'b0011, 32'h5A5A_4A5E, 1'b0, 4, 0));
      wait_drain("field routing");

      // Read return
      ws = 0;
      push_req(0, 32'h486E_0C22, 32'h0, 4'h0);
      exp_q.push_back(mk_exp(0, 32'h486E_0C22, 32'h0, 4'h0, 32'h1234_5678, 1'b0, 1, 0));
      wait_drain("read return");

      // Watchdog abort, then mem_ready exactly in the last allowed cycle
      never = 1;
      push_req(0, 32'h0000_0100, 32'h0, 4'h0);
      exp_q.push_back(mk_exp(0, 32'h0000_0100, 32'h0, 4'h0, 32'hFFFF_FFFF, 1'b1, 5, 0));
      wait_drain("watchdog abort");
      never = 0;
      ws    = 4;
      push_req(0, 32'h0000_0100, 32'h0, 4'h0);
      exp_q.push_back(mk_exp(0, 32'h0000_0100, 32'h0, 4'h0, 32'h5A5A_5B5A, 1'b0, 5, 0));
      wait_drain("watchdog ready wins");

      // Async reset during GNT1; the lost transaction is retried after req0
      ws    = 0;
      never = 1;
      push_req(1, 32'h0000_4000, 32'h55AA_55AA, 4'hC);
      exp_q.push_back(mk_exp(1, 32'h0000_4000, 32'h55AA_55AA, 4'hC, 32'h5A5A_1A5A, 1'b0, 1, 2));
      n = 0;
      do begin @(negedge clk); n++; end while (!mem_valid && n < 20);
      chk("GNT1 reached before reset", 32'(mem_valid), 32'h1);
      @(posedge clk); #3 resetn = 1'b0;
      #1;
      chk("mem_valid drops on async reset", 32'(mem_valid), 32'h0);
      chk("req1_ready on async reset", 32'(req1_ready), 32'h0);
      chk("timeout_err on async reset", 32'(timeout_err), 32'h0);
      never = 0;
      push_req(0, 32'h0000_5000, 32'h0102_0304, 4'h1);
      exp_q.push_front(mk_exp(0, 32'h0000_5000, 32'h0102_0304, 4'h1, 32'h5A5A_0A5A, 1'b0, 1, 0));
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;
      @(negedge clk);
      chk("mem_valid idle after second release", 32'(mem_valid), 32'h0);
      @(negedge clk);
      chk("tie after reset grants req0", mem_addr, 32'h0000_5000);
      wait_drain("async reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
